morse_key_decoder: RTL



---
 rtl/morse_key_decoder_if.sv | 28 ++
 rtl/morse_key_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/morse_key_decoder_if.sv
// Key-decoder bus: key/clear controls in, decoded symbol bank and status out.
//   key_in     raw key level (1 = pressed), asynchronous to clk
//   clear      synchronous bank/partial-symbol clear
//   code_out   last completed symbol, code_valid pulses on update
//   sym_err    pulse on partial-symbol timeout, ovf pulse on full-bank drop
//   count      stored symbols 0..8, codes bank (slot k = codes[5k+4:5k])
//   busy       decoder not idle
interface morse_key_decoder_if;
    logic        key_in;
    logic        clear;
    logic [4:0]  code_out;
    logic        code_valid;
    logic        sym_err;
    logic        ovf;
    logic [3:0]  count;
    logic [39:0] codes;
    logic        busy;

    modport master (
        output key_in, clear,
        input  code_out, code_valid, sym_err, ovf, count, codes, busy
    );

    modport slave (
        input  key_in, clear,
        output code_out, code_valid, sym_err, ovf, count, codes, busy
    );
endinterface

// File: rtl/morse_key_decoder.sv
// Morse key decoder: times key presses, classifies short/long, assembles
// 5-element symbols MSB-first and stores up to 8 of them in a bank.
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   morse_key_decoder_if.slave (key_in/clear in, decoded results out)
module morse_key_decoder #(
    parameter int unsigned CNT_W     = 26,
    parameter int unsigned MIN_PRESS = 1000000,
    parameter int unsigned LONG_TH   = 30000000,
    parameter int unsigned GAP_TO    = 60000000
) (
    input  logic                   clk,
    input  logic                   rst,
    morse_key_decoder_if.slave     bus
);
    localparam int unsigned CODE_W = 5;
    localparam int unsigned SLOTS  = 8;
    localparam int unsigned BANK_W = CODE_W * SLOTS;

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t              state_q, state_d;
    logic                key_meta_q, key_meta_d;
    logic                key_s_q, key_s_d;
    logic [CNT_W-1:0]    press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [3:0]          shreg_q, shreg_d;
    logic [2:0]          elem_cnt_q, elem_cnt_d;
    logic [3:0]          count_q, count_d;
    logic [BANK_W-1:0]   codes_q, codes_d;
    logic [CODE_W-1:0]   code_out_q, code_out_d;
    logic                code_valid_q, code_valid_d;
    logic                sym_err_q, sym_err_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;

    logic                elem_bit;
    logic [CODE_W-1:0]   new_code;

    // Element classification for the press just released; shreg holds the
    // earlier elements so the completed code is {shreg, new element}.
    assign elem_bit = (press_cnt_q >= CNT_W'(LONG_TH));
    assign new_code = {shreg_q, elem_bit};

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        key_meta_d   = bus.key_in;
        key_s_d      = key_meta_q;
        press_cnt_d  = press_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        shreg_d      = shreg_q;
        elem_cnt_d   = elem_cnt_q;
        count_d      = count_q;
        codes_d      = codes_q;
        code_out_d   = code_out_q;
        code_valid_d = 1'b0;
        sym_err_d    = 1'b0;
        ovf_d        = 1'b0;

        if (bus.clear) begin
            // Overrides any completion on this edge; code_out is kept.
            state_d     = IDLE;
            press_cnt_d = '0;
            gap_cnt_d   = '0;
            shreg_d     = '0;
            elem_cnt_d  = '0;
            count_d     = '0;
            codes_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (key_s_q) begin
                        state_d     = PRESS;
                        press_cnt_d = CNT_W'(1);
                    end
                end
                PRESS: begin
                    if (key_s_q) begin
                        if (press_cnt_q < CNT_W'(LONG_TH))
                            press_cnt_d = press_cnt_q + CNT_W'(1);
                    end else if (press_cnt_q < CNT_W'(MIN_PRESS)) begin
                        // Glitch: drop it, resume wherever we were.
                        gap_cnt_d = '0;
                        state_d   = (elem_cnt_q != 3'd0) ? GAP : IDLE;
                    end else if (elem_cnt_q == 3'd4) begin
                        code_out_d   = new_code;
                        code_valid_d = 1'b1;
                        if (count_q < 4'(SLOTS)) begin
                            for (int unsigned k = 0; k < SLOTS; k++) begin
                                if (count_q == 4'(k))
                                    codes_d[CODE_W*k +: CODE_W] = new_code;
                            end
                            count_d = count_q + 4'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        shreg_d    = '0;
                        elem_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        shreg_d    = new_code[3:0];
                        elem_cnt_d = elem_cnt_q + 3'd1;
                        gap_cnt_d  = '0;
                        state_d    = GAP;
                    end
                end
                GAP: begin
                    if (key_s_q) begin
                        state_d     = PRESS;
                        press_cnt_d = CNT_W'(1);
                    end else if (gap_cnt_q == CNT_W'(GAP_TO - 1)) begin
                        sym_err_d  = 1'b1;
                        shreg_d    = '0;
                        elem_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            key_meta_q   <= 1'b0;
            key_s_q      <= 1'b0;
            press_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            shreg_q      <= '0;
            elem_cnt_q   <= '0;
            count_q      <= '0;
            codes_q      <= '0;
            code_out_q   <= '0;
            code_valid_q <= 1'b0;
            sym_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_meta_q   <= key_meta_d;
            key_s_q      <= key_s_d;
            press_cnt_q  <= press_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            shreg_q      <= shreg_d;
            elem_cnt_q   <= elem_cnt_d;
            count_q      <= count_d;
            codes_q      <= codes_d;
            code_out_q   <= code_out_d;
            code_valid_q <= code_valid_d;
            sym_err_q    <= sym_err_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.code_out   = code_out_q;
    assign bus.code_valid = code_valid_q;
    assign bus.sym_err    = sym_err_q;
    assign bus.ovf        = ovf_q;
    assign bus.count      = count_q;
    assign bus.codes      = codes_q;
    assign bus.busy       = busy_q;
endmodule
